// File: rtl/mux_tree_pkg.sv
// mux_tree_pkg: shared constants and helpers for the pipelined mux tree.
//   MODE_MANUAL / MODE_SCAN : encodings of the mode input.
//   sel_off()               : bit offset of a tree level's select-remainder
//                             slot inside the top's flattened select bus.
package mux_tree_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // The select remainder at level k is (selw - k) bits wide.
  // The slots are packed back to back, so the offset of slot k is
  // sum_{j<k} (selw - j).
  function automatic int sel_off(input int selw, input int k);
    return k * selw - (k * (k - 1)) / 2;
  endfunction

endpackage

// File: rtl/mux_tree_level.sv
// mux_tree_level: one level of the pipelined mux tree.
// NIN input channels are reduced to NIN/2 by 2:1 muxes that are steered by
// bit 0 of the select remainder. The results are then registered together
// with the rest of the select bits, the channel index and valid.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   data_i     : NIN packed channels, channel i = data_i[i*WIDTH +: WIDTH]
//   sel_i      : remaining select bits (bit 0 is resolved here)
//   ch_i       : originating channel index (passed through)
//   valid_i    : this level's inputs carry a sample
//   data_o     : NIN/2 registered channels
//   sel_o      : registered select remainder (sel_i >> 1)
//   ch_o       : registered channel index
//   valid_o    : registered valid
// Handshake: valid-only, no ready. A level takes a sample on every edge
// where valid_i=1. Its payload registers hold their value while valid is
// low, and valid_o tracks valid_i one cycle later.
module mux_tree_level
  import mux_tree_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIN   = 2,
  parameter int SELR  = 1,
  parameter int CHW   = 1,
  localparam int SELO = (SELR > 1) ? SELR - 1 : 1,
  localparam int NOUT = NIN / 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NIN*WIDTH-1:0]  data_i,
  input  logic [SELR-1:0]       sel_i,
  input  logic [CHW-1:0]        ch_i,
  input  logic                  valid_i,
  output logic [NOUT*WIDTH-1:0] data_o,
  output logic [SELO-1:0]       sel_o,
  output logic [CHW-1:0]        ch_o,
  output logic                  valid_o
);

  logic [NOUT*WIDTH-1:0] data_d, data_q;
  logic [SELO-1:0]       sel_d, sel_q;
  logic [CHW-1:0]        ch_q;
  logic                  valid_q;

  always_comb begin
    data_d = '0;
    for (int j = 0; j < NOUT; j++) begin
      data_d[j*WIDTH +: WIDTH] = sel_i[0] ? data_i[(2*j+1)*WIDTH +: WIDTH]
                                          : data_i[(2*j)*WIDTH +: WIDTH];
    end
    // On the last level there are no bits left to pass on, so the single
    // remainder bit is always zero.
    sel_d = SELO'(sel_i >> 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel_q   <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_d;
        sel_q  <= sel_d;
        ch_q   <= ch_i;
      end
    end
  end

  assign data_o  = data_q;
  assign sel_o   = sel_q;
  assign ch_o    = ch_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: a pipelined CH:1 mux built as a binary tree with one
// register stage per level. The latency is LEVELS cycles and the block
// accepts one sample per cycle. A valid flag and the source channel index
// travel with each sample.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   in_data    : CH packed channels, channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid   : a sample is presented this cycle
//   mode       : MODE_MANUAL uses sel, MODE_SCAN uses the round-robin counter
//   sel        : channel index in manual mode
//   out_data   : selected sample; holds the last valid one while idle
//   out_valid  : one-cycle pulse per sample that leaves the tree
//   out_ch     : channel index that out_data came from
// Handshake: valid-only, no ready. Every cycle with in_valid=1 is accepted
// unconditionally, and out_valid pulses once per accepted sample, in order.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CH     = 8,
  parameter int SELW   = $clog2(CH),
  parameter int LEVELS = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic                in_valid,
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  output logic [SELW-1:0]     out_ch
);

  if (CH < 2 || (CH & (CH - 1)) != 0 || SELW != $clog2(CH) || LEVELS != SELW)
  begin : g_bad_cfg
    $error("mux_tree_pipe: CH must be a power of 2 >= 2, SELW/LEVELS derived");
  end

  // Flattened per-level buses. The level k input occupies a slot of its
  // own, and the slot after the last level is the block output.
  localparam int DATA_BUS_W = (2 * CH - 1) * WIDTH;
  localparam int SEL_BUS_W  = sel_off(SELW, LEVELS) + 1;

  logic [DATA_BUS_W-1:0]      data_bus;
  logic [SEL_BUS_W-1:0]       sel_bus;
  logic [(LEVELS+1)*SELW-1:0] ch_bus;
  logic [LEVELS:0]            valid_bus;
  logic                       unused_sel_rem;

  // Round-robin scan counter. It is cleared in manual mode, so every entry
  // into scan mode begins at channel 0. It advances only on accepted
  // samples and wraps for free because CH is a power of 2.
  logic [SELW-1:0] scan_cnt_d, scan_cnt_q;
  logic [SELW-1:0] eff_sel;

  always_comb begin
    scan_cnt_d = scan_cnt_q;
    if (mode == MODE_MANUAL) begin
      scan_cnt_d = '0;
    end else if (in_valid) begin
      scan_cnt_d = scan_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
    end
  end

  assign eff_sel = (mode == MODE_SCAN) ? scan_cnt_q : sel;

  assign data_bus[0 +: CH*WIDTH] = in_data;
  assign sel_bus[0 +: SELW]      = eff_sel;
  assign ch_bus[0 +: SELW]       = eff_sel;
  assign valid_bus[0]            = in_valid;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NIN    = CH >> k;
    localparam int DOFF_I = (2 * CH - 2 * (CH >> k)) * WIDTH;
    localparam int DOFF_O = (2 * CH - 2 * (CH >> (k + 1))) * WIDTH;
    localparam int SR     = SELW - k;
    localparam int SO     = (SR > 1) ? SR - 1 : 1;
    localparam int SOFF_I = sel_off(SELW, k);
    localparam int SOFF_O = sel_off(SELW, k + 1);

    mux_tree_level #(
      .WIDTH (WIDTH),
      .NIN   (NIN),
      .SELR  (SR),
      .CHW   (SELW)
    ) u_level (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_i  (data_bus[DOFF_I +: NIN*WIDTH]),
      .sel_i   (sel_bus[SOFF_I +: SR]),
      .ch_i    (ch_bus[k*SELW +: SELW]),
      .valid_i (valid_bus[k]),
      .data_o  (data_bus[DOFF_O +: (NIN/2)*WIDTH]),
      .sel_o   (sel_bus[SOFF_O +: SO]),
      .ch_o    (ch_bus[(k+1)*SELW +: SELW]),
      .valid_o (valid_bus[k+1])
    );
  end

  // The last level's select remainder is always zero. Nothing reads it.
  assign unused_sel_rem = sel_bus[SEL_BUS_W-1];

  assign out_data  = data_bus[DATA_BUS_W-1 -: WIDTH];
  assign out_ch    = ch_bus[LEVELS*SELW +: SELW];
  assign out_valid = valid_bus[LEVELS];

endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined N:1 multiplexer built as a binary tree of 2:1 mux levels, with one register stage per tree level and a valid flag that travels with each sample. It succeeds the fixed 4:1 two-level mux tree: width and channel count are parameters, and an auto-scan mode steps through the channels in round-robin order. It sits between multi-channel sample sources and a single-stream consumer that needs one channel per cycle at full clock rate.

## Interface
- WIDTH, 8, bits per channel sample.
- CH, 8, number of input channels. Must be a power of 2 and ≥2; any other value is an elaboration error.
- SELW, $clog2(CH), select/channel-index width (derived; do not override).
- LEVELS, $clog2(CH), tree depth and pipeline latency (derived).

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  CH*WIDTH  packed channels; channel i = in_data[i*WIDTH +: WIDTH].
- in_valid  input  1  a sample is presented this cycle.
- mode  input  1  0 = manual (use sel), 1 = scan (use internal counter).
- sel  input  SELW  channel index in manual mode.
- out_data  output  WIDTH  selected sample.
- out_valid  output  1  out_data/out_ch carry a new sample this cycle.
- out_ch  output  SELW  channel index out_data came from.

## Operation
- Effective select: eff_sel = sel when mode=0, scan_cnt when mode=1. Captured at the input edge together with in_data and in_valid.
- Tree level k (k=0..LEVELS-1) resolves select bit k (LSB first). Level 0 has CH/2 2:1 muxes; each subsequent level halves the count. Each level registers its mux outputs, the remaining select bits, the channel index, and valid.
- Stage data, select and channel registers load only when the incoming valid is 1. The valid register loads every cycle. Result: out_data and out_ch hold the last valid sample while out_valid=0.
- Scan counter scan_cnt (SELW bits):
  - held at 0 while mode=0;
  - when mode=1, increments by 1 on every cycle with in_valid=1;
  - wraps CH-1 → 0;
  - does not advance on cycles with in_valid=0.
  - The first valid sample after entering scan mode therefore comes from channel 0.
- Changing sel or mode never affects samples already in the pipeline.
- No backpressure: the block accepts one sample per cycle unconditionally.

## Timing
- Latency is LEVELS cycles. A sample captured at edge n appears on the outputs after edge n+LEVELS-1, with out_valid=1 for exactly one cycle per input sample.
- Throughput is 1 sample/cycle. Back-to-back valid inputs produce back-to-back valid outputs in the same order, with no gaps.
- Reset (rst_n=0 sampled at an edge):
  - all stage registers clear: out_data=0, out_valid=0, out_ch=0, scan_cnt=0;
  - in-flight samples are discarded, not completed;
  - no output asserts valid until LEVELS cycles after the first valid input following reset release.
- in_valid=1 coinciding with rst_n=0: the sample is dropped and scan_cnt stays 0.
- mode toggled 1→0→1: scan_cnt restarts at 0.

## Structure
- Package mux_tree_pkg holds the constants MODE_MANUAL=1'b0 and MODE_SCAN=1'b1.
- Sub-module mux_tree_level, parameterised by WIDTH, input channel count and remaining select width. It contains one tree level (2:1 muxes plus register stage with valid, select-remainder and channel-index pass-through).
- mux_tree_pipe instantiates LEVELS of mux_tree_level in a generate loop, plus the scan counter and the eff_sel logic.

## Test plan
All scenarios use CH=4, WIDTH=8 (LEVELS=2), with in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA} (channel 0 = AA).
1. **Reset:** hold rst_n=0 for 2 edges with in_valid=1 and random data → out_valid=0, out_data=0x00, out_ch=0 throughout, and no valid output in the 2 cycles after release.
2. **Manual single sample:** mode=0, sel=2, in_valid=1 for one edge n → after edge n+1, out_valid=1, out_data=0xCC, out_ch=2; out_valid returns to 0 the next cycle while out_data stays 0xCC.
3. **Manual back-to-back:** sel=0,1,2,3 on 4 consecutive valid cycles → 4 consecutive outputs AA, BB, CC, DD with out_ch 0..3 and no gaps. Changing sel to 0 while these are in flight does not alter them.
4. **Scan mode with gaps:** mode=1, in_valid pattern 1,1,0,1,1,1 → valid outputs have out_ch 0,1,2,3,0 and data AA, BB, CC, DD, AA. The gap cycle produces an out_valid=0 hole and the counter does not advance across it.
5. **Mode re-entry:** scan through 3 samples, set mode=0 for 1 cycle, return to mode=1 → the next scanned sample is out_ch=0 (0xAA).
6. **Reset mid-flight:** 2 valid samples in the pipeline, then rst_n=0 for 1 edge → neither sample appears, outputs are 0, and the next scan sample comes from channel 0.
